// File: rtl/rtc_timekeeper.sv
// rtl/rtc_timekeeper.sv - prescaled hh:mm:ss time-of-day core with load handshake and 12h/24h display
// Optional alarm compare enabled by defining RTC_TIMEKEEPER_ALARM_EN.
module rtc_timekeeper #(
   parameter int CLK_HZ       = 50000000,
   parameter int DOT_DUTY_DIV = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       mode12,
   input  logic       set_valid,
   output logic       set_ready,
   input  logic [4:0] set_hour,
   input  logic [5:0] set_min,
   input  logic [5:0] set_sec,
   output logic       set_err,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic [4:0] hour,
   output logic       pm,
   output logic       dot,
   output logic       tick,
   input  logic [4:0] alarm_hour,
   input  logic [5:0] alarm_min,
   input  logic       alarm_ack,
   output logic       alarm
);

   localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
   localparam logic [PW:0]   DOT_LIMIT  = (PW+1)'(CLK_HZ / DOT_DUTY_DIV);

   logic [PW-1:0] r_presc;
   logic [5:0]    r_sec;
   logic [5:0]    r_min;
   logic [4:0]    r_hr;
   logic          r_tick;
   logic          r_err;
   logic          r_ready;

   logic          w_roll;
   logic          w_load;
   logic          w_in_range;
   logic          w_load_ok;
   logic          w_sec_wrap;
   logic          w_min_wrap;
   logic [5:0]    w_sec_n;
   logic [5:0]    w_min_n;
   logic [4:0]    w_hr_n;
   logic [4:0]    w_hr_mod;

   assign w_roll     = (r_presc == PRESC_LAST);
   assign w_load     = set_valid & r_ready;
   assign w_in_range = (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59);
   assign w_load_ok  = w_load & w_in_range;

   // Next time on a one-second increment, with the full carry chain in one edge.
   assign w_sec_wrap = (r_sec == 6'd59);
   assign w_min_wrap = w_sec_wrap && (r_min == 6'd59);
   assign w_sec_n    = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
   assign w_min_n    = w_sec_wrap ? ((r_min == 6'd59) ? 6'd0 : r_min + 6'd1) : r_min;
   assign w_hr_n     = w_min_wrap ? ((r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1) : r_hr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc <= '0;
         r_sec   <= '0;
         r_min   <= '0;
         r_hr    <= '0;
         r_tick  <= 1'b0;
         r_err   <= 1'b0;
         r_ready <= 1'b0;
      end else begin
         r_ready <= 1'b1;
         r_tick  <= 1'b0;
         r_err   <= 1'b0;
         if (w_load_ok) begin
            // A valid load overrides any coincident rollover.
            r_hr    <= set_hour;
            r_min   <= set_min;
            r_sec   <= set_sec;
            r_presc <= '0;
         end else begin
            if (w_load) begin
               r_err <= 1'b1;
            end
            if (enable) begin
               if (w_roll) begin
                  r_presc <= '0;
                  r_sec   <= w_sec_n;
                  r_min   <= w_min_n;
                  r_hr    <= w_hr_n;
                  r_tick  <= 1'b1;
               end else begin
                  r_presc <= r_presc + PW'(1);
               end
            end
         end
      end
   end

`ifdef RTC_TIMEKEEPER_ALARM_EN
   logic r_alarm;
   logic w_alarm_set;

   assign w_alarm_set = enable && w_roll && !w_load_ok && (w_sec_n == 6'd0) &&
                        (w_min_n == alarm_min) && (w_hr_n == alarm_hour);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_alarm <= 1'b0;
      end else if (w_alarm_set) begin
         r_alarm <= 1'b1;
      end else if (alarm_ack) begin
         r_alarm <= 1'b0;
      end
   end

   assign alarm = r_alarm;
`else
   logic w_unused_alarm;
   assign w_unused_alarm = ^{alarm_hour, alarm_min, alarm_ack};
   assign alarm          = 1'b0;
`endif

   assign w_hr_mod  = (r_hr >= 5'd12) ? r_hr - 5'd12 : r_hr;
   assign hour      = mode12 ? ((w_hr_mod == 5'd0) ? 5'd12 : w_hr_mod) : r_hr;
   assign pm        = (r_hr >= 5'd12);
   assign dot       = ({1'b0, r_presc} < DOT_LIMIT);
   assign sec       = r_sec;
   assign min       = r_min;
   assign tick      = r_tick;
   assign set_err   = r_err;
   assign set_ready = r_ready;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb/tb_rtc_timekeeper.sv - directed self-checking bench for rtc_timekeeper at CLK_HZ=10
module tb_rtc_timekeeper;

`ifdef RTC_TIMEKEEPER_ALARM_EN
   localparam logic ALARM_ON = 1'b1;
`else
   localparam logic ALARM_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       mode12 = 1'b0;
   logic       set_valid = 1'b0;
   logic       set_ready;
   logic [4:0] set_hour = '0;
   logic [5:0] set_min = '0;
   logic [5:0] set_sec = '0;
   logic       set_err;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic       pm;
   logic       dot;
   logic       tick;
   logic [4:0] alarm_hour = '0;
   logic [5:0] alarm_min = '0;
   logic       alarm_ack = 1'b0;
   logic       alarm;

   int n_checks = 0;
   int n_fail   = 0;

   rtc_timekeeper #(.CLK_HZ(10), .DOT_DUTY_DIV(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .mode12(mode12),
      .set_valid(set_valid), .set_ready(set_ready), .set_hour(set_hour),
      .set_min(set_min), .set_sec(set_sec), .set_err(set_err),
      .sec(sec), .min(min), .hour(hour), .pm(pm), .dot(dot), .tick(tick),
      .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_ack(alarm_ack),
      .alarm(alarm)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
      set_valid = 1'b1;
      set_hour  = h;
      set_min   = m;
      set_sec   = s;
      step();
      set_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      n_checks++;
      if ({set_ready, sec, min, hour, pm, dot, tick, set_err, alarm} !== {1'b0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: ready=%0b sec=%0d min=%0d hour=%0d pm=%0b dot=%0b tick=%0b err=%0b alarm=%0b, want 0 0 0 0 0 1 0 0 0",
                  set_ready, sec, min, hour, pm, dot, tick, set_err, alarm);
      end
      reset = 1'b0;
      step();
      n_checks++;
      if (set_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset: got %0b want 1", set_ready);
      end
      mode12 = 1'b1;
      #1;
      n_checks++;
      if (hour !== 5'd12) begin
         n_fail++;
         $display("FAIL reset_hour_12h: got %0d want 12", hour);
      end
      mode12 = 1'b0;
      #1;
   endtask

   task automatic test_prescaler();
      int ticks = 0;
      int exp_p;
      enable = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         exp_p = i % 10;
         if (tick === 1'b1) ticks++;
         n_checks++;
         if (dot !== (exp_p < 5)) begin
            n_fail++;
            $display("FAIL dot_presc%0d: got %0b want %0b", exp_p, dot, (exp_p < 5));
         end
         n_checks++;
         if (sec !== ((i == 10) ? 6'd1 : 6'd0)) begin
            n_fail++;
            $display("FAIL sec_step%0d: got %0d want %0d", i, sec, (i == 10) ? 1 : 0);
         end
      end
      n_checks++;
      if (ticks != 1 || tick !== 1'b1) begin
         n_fail++;
         $display("FAIL tick_once: ticks=%0d tick_now=%0b want 1 1", ticks, tick);
      end
      step();
      n_checks++;
      if (tick !== 1'b0) begin
         n_fail++;
         $display("FAIL tick_one_cycle: got %0b want 0", tick);
      end
      enable = 1'b0;
      ticks = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (tick === 1'b1) ticks++;
      end
      n_checks++;
      if (sec !== 6'd1 || ticks != 0 || dot !== 1'b1) begin
         n_fail++;
         $display("FAIL frozen: sec=%0d ticks=%0d dot=%0b want 1 0 1", sec, ticks, dot);
      end
   endtask

   task automatic test_wrap();
      int ticks = 0;
      enable = 1'b1;
      do_load(5'd23, 6'd59, 6'd59);
      n_checks++;
      if ({hour, min, sec, pm} !== {5'd23, 6'd59, 6'd59, 1'b1}) begin
         n_fail++;
         $display("FAIL load_23_59_59: got %0d:%0d:%0d pm=%0b want 23:59:59 pm=1", hour, min, sec, pm);
      end
      for (int i = 1; i <= 10; i++) begin
         step();
         if (tick === 1'b1) ticks++;
      end
      n_checks++;
      if ({hour, min, sec, pm} !== {5'd0, 6'd0, 6'd0, 1'b0} || ticks != 1) begin
         n_fail++;
         $display("FAIL day_wrap: got %0d:%0d:%0d pm=%0b ticks=%0d want 0:0:0 pm=0 ticks=1", hour, min, sec, pm, ticks);
      end
      enable = 1'b0;
   endtask

   task automatic test_mode12();
      mode12 = 1'b1;
      do_load(5'd0, 6'd30, 6'd0);
      n_checks++;
      if ({hour, pm, min} !== {5'd12, 1'b0, 6'd30}) begin
         n_fail++;
         $display("FAIL m12_0030: hour=%0d pm=%0b min=%0d want 12 0 30", hour, pm, min);
      end
      do_load(5'd13, 6'd5, 6'd0);
      n_checks++;
      if ({hour, pm, min} !== {5'd1, 1'b1, 6'd5}) begin
         n_fail++;
         $display("FAIL m12_1305: hour=%0d pm=%0b min=%0d want 1 1 5", hour, pm, min);
      end
      do_load(5'd12, 6'd0, 6'd0);
      n_checks++;
      if ({hour, pm} !== {5'd12, 1'b1}) begin
         n_fail++;
         $display("FAIL m12_1200: hour=%0d pm=%0b want 12 1", hour, pm);
      end
      mode12 = 1'b0;
      #1;
      n_checks++;
      if ({hour, pm} !== {5'd12, 1'b1}) begin
         n_fail++;
         $display("FAIL m24_1200: hour=%0d pm=%0b want 12 1", hour, pm);
      end
   endtask

   task automatic test_bad_load();
      int ticks = 0;
      enable = 1'b1;
      for (int i = 0; i < 6; i++) step();
      enable = 1'b0;
      n_checks++;
      if (dot !== 1'b0) begin
         n_fail++;
         $display("FAIL dot_presc6: got %0b want 0", dot);
      end
      do_load(5'd5, 6'd60, 6'd0);
      n_checks++;
      if ({set_err, hour, min, sec, dot} !== {1'b1, 5'd12, 6'd0, 6'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL bad_min: err=%0b time=%0d:%0d:%0d dot=%0b want 1 12:0:0 0", set_err, hour, min, sec, dot);
      end
      step();
      n_checks++;
      if (set_err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_one_cycle: got %0b want 0", set_err);
      end
      do_load(5'd24, 6'd0, 6'd0);
      n_checks++;
      if ({set_err, hour, min, sec, dot} !== {1'b1, 5'd12, 6'd0, 6'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL bad_hour: err=%0b time=%0d:%0d:%0d dot=%0b want 1 12:0:0 0", set_err, hour, min, sec, dot);
      end
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (tick === 1'b1) ticks++;
      end
      enable = 1'b0;
      n_checks++;
      if (sec !== 6'd1 || ticks != 1 || tick !== 1'b1) begin
         n_fail++;
         $display("FAIL presc_retained: sec=%0d ticks=%0d tick=%0b want 1 1 1", sec, ticks, tick);
      end
   endtask

   task automatic test_back_to_back();
      set_valid = 1'b1;
      set_hour = 5'd1; set_min = 6'd2; set_sec = 6'd3;
      step();
      n_checks++;
      if ({hour, min, sec} !== {5'd1, 6'd2, 6'd3}) begin
         n_fail++;
         $display("FAIL b2b_first: got %0d:%0d:%0d want 1:2:3", hour, min, sec);
      end
      set_hour = 5'd4; set_min = 6'd5; set_sec = 6'd6;
      step();
      n_checks++;
      if ({hour, min, sec, set_err} !== {5'd4, 6'd5, 6'd6, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_second: got %0d:%0d:%0d err=%0b want 4:5:6 0", hour, min, sec, set_err);
      end
      set_hour = 5'd10; set_min = 6'd0; set_sec = 6'd61;
      step();
      set_valid = 1'b0;
      n_checks++;
      if ({hour, min, sec, set_err} !== {5'd4, 6'd5, 6'd6, 1'b1}) begin
         n_fail++;
         $display("FAIL b2b_third_bad: got %0d:%0d:%0d err=%0b want 4:5:6 1", hour, min, sec, set_err);
      end
   endtask

   task automatic test_load_at_rollover();
      enable = 1'b1;
      do_load(5'd0, 6'd0, 6'd0);
      for (int i = 0; i < 9; i++) step();
      do_load(5'd5, 6'd0, 6'd0);
      n_checks++;
      if ({hour, min, sec, tick} !== {5'd5, 6'd0, 6'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL load_on_roll: got %0d:%0d:%0d tick=%0b want 5:0:0 0", hour, min, sec, tick);
      end
      for (int i = 0; i < 9; i++) step();
      n_checks++;
      if (sec !== 6'd0 || tick !== 1'b0) begin
         n_fail++;
         $display("FAIL roll_early: sec=%0d tick=%0b want 0 0", sec, tick);
      end
      step();
      n_checks++;
      if ({hour, min, sec, tick} !== {5'd5, 6'd0, 6'd1, 1'b1}) begin
         n_fail++;
         $display("FAIL roll_after_load: got %0d:%0d:%0d tick=%0b want 5:0:1 1", hour, min, sec, tick);
      end
      enable = 1'b0;
   endtask

   task automatic test_alarm();
      alarm_hour = 5'd7;
      alarm_min  = 6'd0;
      enable = 1'b1;
      do_load(5'd6, 6'd59, 6'd59);
      for (int i = 0; i < 9; i++) step();
      n_checks++;
      if (alarm !== 1'b0) begin
         n_fail++;
         $display("FAIL alarm_early: got %0b want 0", alarm);
      end
      step();
      n_checks++;
      if ({hour, min, sec, alarm} !== {5'd7, 6'd0, 6'd0, ALARM_ON}) begin
         n_fail++;
         $display("FAIL alarm_set: got %0d:%0d:%0d alarm=%0b want 7:0:0 %0b", hour, min, sec, alarm, ALARM_ON);
      end
      step();
      n_checks++;
      if (alarm !== ALARM_ON) begin
         n_fail++;
         $display("FAIL alarm_sticky: got %0b want %0b", alarm, ALARM_ON);
      end
      alarm_ack = 1'b1;
      step();
      alarm_ack = 1'b0;
      n_checks++;
      if (alarm !== 1'b0) begin
         n_fail++;
         $display("FAIL alarm_ack: got %0b want 0", alarm);
      end
      enable = 1'b0;
      do_load(5'd7, 6'd0, 6'd0);
      step();
      n_checks++;
      if (alarm !== 1'b0) begin
         n_fail++;
         $display("FAIL alarm_by_load: got %0b want 0", alarm);
      end
      enable = 1'b1;
      do_load(5'd6, 6'd59, 6'd59);
      for (int i = 0; i < 9; i++) step();
      alarm_ack = 1'b1;
      step();
      alarm_ack = 1'b0;
      n_checks++;
      if (alarm !== ALARM_ON) begin
         n_fail++;
         $display("FAIL alarm_set_beats_ack: got %0b want %0b", alarm, ALARM_ON);
      end
      reset = 1'b1;
      set_valid = 1'b1;
      set_hour = 5'd10; set_min = 6'd10; set_sec = 6'd10;
      step();
      set_valid = 1'b0;
      reset = 1'b0;
      n_checks++;
      if ({alarm, hour, min, sec, tick, set_ready} !== {1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_wins: alarm=%0b time=%0d:%0d:%0d tick=%0b ready=%0b want 0 0:0:0 0 0",
                  alarm, hour, min, sec, tick, set_ready);
      end
      enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_prescaler();
      test_wrap();
      test_mode12();
      test_bad_load();
      test_back_to_back();
      test_load_at_rollover();
      test_alarm();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
Parametrised time-of-day core that replaces the separate fixed clock divider and fixed hh:mm:ss counter.
- Derives the 1 Hz tick from the system clock through an internal prescaler.
- Keeps seconds, minutes and hours.
- Accepts a validated time load over a valid/ready handshake.
- Supports 12h/24h display mode and drives a blink dot.
- Outputs feed the existing seven-segment LED controller directly.

Parameters:
- CLK_HZ, 50000000, system clock cycles per second; must be >= 2; benches use 10.
- DOT_DUTY_DIV, 2, dot is high for the first CLK_HZ/DOT_DUTY_DIV cycles of each second.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = time runs; 0 = prescaler and counters frozen.
- mode12  in  1  1 = 12-hour display, 0 = 24-hour display.
- set_valid  in  1  time load request.
- set_ready  out  1  load can be accepted.
- set_hour  in  5  load value, 24h format.
- set_min  in  6  load value.
- set_sec  in  6  load value.
- set_err  out  1  one-cycle pulse: load rejected as out of range.
- sec  out  6  seconds 0..59.
- min  out  6  minutes 0..59.
- hour  out  5  display hour: 0..23, or 1..12 when mode12=1.
- pm  out  1  1 when internal hour >= 12, in both modes.
- dot  out  1  blink indicator.
- tick  out  1  one-cycle pulse per second increment.
- alarm_hour  in  5  alarm time, 24h (ALARM_EN only).
- alarm_min  in  6  alarm time (ALARM_EN only).
- alarm_ack  in  1  clears alarm (ALARM_EN only).
- alarm  out  1  sticky alarm flag (ALARM_EN only).

Behaviour:
- Reset: on a rising clk edge with reset=1, the following are cleared to 0:
  - prescaler, internal hour (hr24), min, sec
  - tick, set_err, alarm
- Output values during and right after reset:
  - set_ready=0 during reset, 1 from the first cycle after reset and thereafter.
  - dot=1 (prescaler=0); hour=0 in 24h mode, 12 in 12h mode; pm=0.
- Prescaler:
  - Counts 0..CLK_HZ-1 while enable=1.
  - On the edge where prescaler==CLK_HZ-1 and enable=1: prescaler->0, sec increments, and tick is registered high for exactly the next cycle.
  - tick therefore coincides with the cycle in which the new sec is visible.
- Cascade, all on the same edge:
  - sec 59->0 carries into min.
  - min 59->0 carries into hr24.
  - hr24 23->0 wraps the day.
- Display mapping (combinational from registers):
  - mode12=0: hour=hr24.
  - mode12=1: hour = hr24 mod 12, with 0 shown as 12.
  - pm = (hr24 >= 12).
  - A mode12 change takes effect combinationally with no state change.
- dot = (prescaler < CLK_HZ/DOT_DUTY_DIV), combinational. It holds its value while enable=0.
- Load handshake: accepted on an edge with set_valid=1 and set_ready=1.
  - In range (set_hour<=23, set_min<=59, set_sec<=59): hr24/min/sec take the load values and prescaler->0.
  - A load that coincides with a prescaler rollover wins: no increment, and tick stays 0 the next cycle.
  - Out of range: no state change; set_err=1 for the next cycle only.
  - Loads are accepted while enable=0.
  - Back-to-back loads on consecutive cycles are each processed.
- enable=0: no increments, no tick. The prescaler value is retained and resumes from the same count.
- Reset asserted mid-count or mid-load: reset wins over everything.

Optional Feature:
Macro name: RTC_TIMEKEEPER_ALARM_EN.
- Defined:
  - alarm sets on the increment edge where the new time is sec=0, min=alarm_min, hr24=alarm_hour.
  - A time load never sets alarm, even if it loads a matching time.
  - alarm stays 1 until a cycle with alarm_ack=1; it clears on that edge.
  - If a set event and alarm_ack occur on the same edge, set wins (alarm=1).
  - Out-of-range alarm_hour/alarm_min values never match.
- Not defined: alarm ports are still present; alarm is tied to 0 and the alarm inputs are ignored.

Test Plan (CLK_HZ=10):
1. Reset, enable=1, run 10 cycles -> sec=1 exactly once, tick high for 1 cycle; dot=1 for prescaler 0..4 and 0 for 5..9; enable=0 for 20 cycles -> sec stays 1.
2. Load 23:59:59, run 10 cycles -> 00:00:00 with single tick; pm goes 1->0.
3. mode12=1: load 00:30:00 -> hour=12, pm=0; load 13:05:00 -> hour=1, pm=1; load 12:00:00 -> hour=12, pm=1.
4. Load with set_min=60 -> set_err pulse of 1 cycle, time and prescaler unchanged; load with set_hour=24 -> same result.
5. Load 05:00:00 on the edge where prescaler=9 -> time=05:00:00, prescaler=0, no tick next cycle; next tick 10 cycles later -> 05:00:01.
6. ALARM_EN: alarm 07:00, load 06:59:59, run 10 cycles -> alarm=1; alarm_ack -> 0; loading 07:00:00 directly -> alarm stays 0; reset during alarm=1 -> alarm=0.
